// File: rtl/kernel_streamer_3x3.sv
// kernel_streamer_3x3
//   Walks a bank of BUFFER_DEPTH 3x3 kernels in a kernel buffer and sends them out as an
//   AXI-Stream master. For each kernel it drives the kernel select, waits for the buffer to
//   report valid contents, and captures the nine taps. It then sends each tap as
//   BUFFER_WIDTH/WIDTH beats, least-significant slice first.
//
// Ports
//   i_aclk, i_areset     clock; synchronous active-high reset
//   i_start              begin a bank readback (honoured only when idle)
//   o_busy, o_done       busy outside idle; one-cycle done pulse after the final beat
//   o_sel                kernel select driven to the buffer
//   i_buf_valid          buffer contents valid
//   i_buf_00..i_buf_22   nine taps of the selected kernel (row, col)
//   o_tvalid, i_tready   AXIS handshake
//   o_tdata, o_tlast     AXIS payload; tlast on the final beat of the last kernel
module kernel_streamer_3x3 #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned BUFFER_WIDTH = 16,
  parameter int unsigned BUFFER_DEPTH = 8,
  localparam int unsigned SelW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1
) (
  input  logic                    i_aclk,
  input  logic                    i_areset,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [SelW-1:0]         o_sel,
  input  logic                    i_buf_valid,
  input  logic [BUFFER_WIDTH-1:0] i_buf_00,
  input  logic [BUFFER_WIDTH-1:0] i_buf_01,
  input  logic [BUFFER_WIDTH-1:0] i_buf_02,
  input  logic [BUFFER_WIDTH-1:0] i_buf_10,
  input  logic [BUFFER_WIDTH-1:0] i_buf_11,
  input  logic [BUFFER_WIDTH-1:0] i_buf_12,
  input  logic [BUFFER_WIDTH-1:0] i_buf_20,
  input  logic [BUFFER_WIDTH-1:0] i_buf_21,
  input  logic [BUFFER_WIDTH-1:0] i_buf_22,
  output logic                    o_tvalid,
  input  logic                    i_tready,
  output logic [WIDTH-1:0]        o_tdata,
  output logic                    o_tlast
);

  localparam int unsigned Beats  = BUFFER_WIDTH / WIDTH;
  localparam int unsigned KBeats = 9 * Beats;
  localparam int unsigned CntW   = $clog2(KBeats);
  localparam int unsigned ShW    = 9 * BUFFER_WIDTH;

  typedef enum logic [2:0] {StIdle, StSelect, StLoad, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ShW-1:0]  shift_q, shift_d;
  logic            tvalid_q, tvalid_d;

  logic last_beat;
  logic last_kernel;

  assign last_beat   = (cnt_q == CntW'(KBeats - 1));
  assign last_kernel = (sel_q == SelW'(BUFFER_DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tvalid_d = tvalid_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StSelect;
          sel_d   = '0;
          cnt_d   = '0;
        end
      end
      // One cycle for the buffer outputs to follow the new select.
      StSelect: state_d = StLoad;
      StLoad: begin
        if (i_buf_valid) begin
          // Tap 00 sits at the bottom so a plain right shift yields the beat order.
          shift_d  = {i_buf_22, i_buf_21, i_buf_20, i_buf_12, i_buf_11, i_buf_10,
                      i_buf_02, i_buf_01, i_buf_00};
          cnt_d    = '0;
          tvalid_d = 1'b1;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (tvalid_q && i_tready) begin
          if (last_beat) begin
            tvalid_d = 1'b0;
            if (last_kernel) begin
              state_d = StDone;
            end else begin
              sel_d   = sel_q + SelW'(1);
              state_d = StSelect;
            end
          end else begin
            shift_d = shift_q >> WIDTH;
            cnt_d   = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        sel_d   = '0;
      end
      default: begin
        state_d  = StIdle;
        sel_d    = '0;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tvalid_q <= tvalid_d;
    end
  end

  // Outputs come straight from registers, so they cannot react to i_tready.
  assign o_tvalid = tvalid_q;
  assign o_tdata  = tvalid_q ? shift_q[WIDTH-1:0] : '0;
  assign o_tlast  = tvalid_q && last_beat && last_kernel;
  assign o_busy   = (state_q != StIdle);
  assign o_done   = (state_q == StDone);
  assign o_sel    = sel_q;

endmodule

// File: tb/tb_kernel_streamer_3x3.sv
module tb_kernel_streamer_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: WIDTH 8, BUFFER_WIDTH 16, BUFFER_DEPTH 8.
  logic        areset, start, buf_valid, tready;
  logic        busy, done, tvalid, tlast;
  logic [2:0]  sel;
  logic [7:0]  tdata;
  logic [15:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;

  // Tap (r,c) of kernel k = 16'h{k, r, c}: high byte k, low byte {r, c}.
  assign b00 = {5'd0, sel, 4'd0, 4'd0};
  assign b01 = {5'd0, sel, 4'd0, 4'd1};
  assign b02 = {5'd0, sel, 4'd0, 4'd2};
  assign b10 = {5'd0, sel, 4'd1, 4'd0};
  assign b11 = {5'd0, sel, 4'd1, 4'd1};
  assign b12 = {5'd0, sel, 4'd1, 4'd2};
  assign b20 = {5'd0, sel, 4'd2, 4'd0};
  assign b21 = {5'd0, sel, 4'd2, 4'd1};
  assign b22 = {5'd0, sel, 4'd2, 4'd2};

  kernel_streamer_3x3 dut (
    .i_aclk(clk), .i_areset(areset), .i_start(start), .o_busy(busy), .o_done(done),
    .o_sel(sel), .i_buf_valid(buf_valid),
    .i_buf_00(b00), .i_buf_01(b01), .i_buf_02(b02),
    .i_buf_10(b10), .i_buf_11(b11), .i_buf_12(b12),
    .i_buf_20(b20), .i_buf_21(b21), .i_buf_22(b22),
    .o_tvalid(tvalid), .i_tready(tready), .o_tdata(tdata), .o_tlast(tlast)
  );

  // Small instance: WIDTH 8, BUFFER_WIDTH 8, BUFFER_DEPTH 1.
  logic       s_start, s_busy, s_done, s_tvalid, s_tlast;
  logic [0:0] s_sel;
  logic [7:0] s_tdata;

  kernel_streamer_3x3 #(.WIDTH(8), .BUFFER_WIDTH(8), .BUFFER_DEPTH(1)) dut_s (
    .i_aclk(clk), .i_areset(areset), .i_start(s_start), .o_busy(s_busy), .o_done(s_done),
    .o_sel(s_sel), .i_buf_valid(1'b1),
    .i_buf_00(8'h00), .i_buf_01(8'h01), .i_buf_02(8'h02),
    .i_buf_10(8'h10), .i_buf_11(8'h11), .i_buf_12(8'h12),
    .i_buf_20(8'h20), .i_buf_21(8'h21), .i_buf_22(8'h22),
    .o_tvalid(s_tvalid), .i_tready(1'b1), .o_tdata(s_tdata), .o_tlast(s_tlast)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent collect() call.
  logic [7:0] got_d[$];
  logic       got_l[$];
  int         sel_hist[$];
  int         done_cnt, done_cyc, stall_err;
  bit         timed_out;

  function automatic logic [7:0] exp_beat(input int i);
    int k, j, t;
    k = i / 18;
    j = i % 18;
    t = j / 2;
    if (j % 2 == 0) return 8'((t / 3) * 16 + (t % 3));
    return 8'(k);
  endfunction

  // Start pulse; collect()'s first sample is then the negedge after the start edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: tready high; mode 1: tready toggles with an extra stall burst.
  task automatic collect(input int mode, input int budget);
    logic [7:0] pd;
    logic       pl;
    bit         prev_stall;
    int         burst;
    got_d.delete();
    got_l.delete();
    sel_hist.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    stall_err  = 0;
    timed_out  = 0;
    prev_stall = 0;
    pd         = '0;
    pl         = 1'b0;
    burst      = int'($urandom_range(5, 15));
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (mode == 0) tready = 1'b1;
      else tready = (cyc >= 60 && cyc < 60 + burst) ? 1'b0 : (cyc % 2 == 0);
      if (prev_stall && (tvalid !== 1'b1 || tdata !== pd || tlast !== pl)) stall_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        tready   = 1'b1;
        return;
      end
      if (tvalid === 1'b1 && tready) begin
        if (got_d.size() % 18 == 0) sel_hist.push_back(int'(sel));
        got_d.push_back(tdata);
        got_l.push_back(tlast);
      end
      prev_stall = (tvalid === 1'b1) && !tready;
      pd = tdata;
      pl = tlast;
    end
    timed_out = 1;
    tready    = 1'b1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    n_checks++; if (tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got %h want 00", tdata); end
    n_checks++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b want 0", tlast); end
    n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_stream();
    do_start();
    collect(0, 400);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL stream_timeout got no done want done"); end
    n_checks++; if (got_d.size() != 144) begin n_fail++; $display("FAIL stream_count got %0d want 144", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 144; i++) begin
      n_checks++;
      if (got_d[i] !== exp_beat(i) || got_l[i] !== (i == 143)) begin
        n_fail++;
        $display("FAIL stream_beat%0d got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_beat(i), (i == 143));
      end
    end
    n_checks++; if (sel_hist.size() != 8) begin n_fail++; $display("FAIL stream_kernels got %0d want 8", sel_hist.size()); end
    for (int k = 0; k < sel_hist.size() && k < 8; k++) begin
      n_checks++; if (sel_hist[k] != k) begin n_fail++; $display("FAIL stream_sel%0d got %0d want %0d", k, sel_hist[k], k); end
    end
    // 8 kernels x (18 beats + SELECT + LOAD) after the start edge.
    n_checks++; if (done_cyc != 160) begin n_fail++; $display("FAIL stream_latency got %0d want 160", done_cyc); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stream_done_once got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_stall();
    do_start();
    collect(1, 900);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout got no done want done"); end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", stall_err); end
    n_checks++; if (got_d.size() != 144) begin n_fail++; $display("FAIL stall_count got %0d want 144", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 144; i++) begin
      n_checks++;
      if (got_d[i] !== exp_beat(i) || got_l[i] !== (i == 143)) begin
        n_fail++;
        $display("FAIL stall_beat%0d got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_beat(i), (i == 143));
      end
    end
  endtask

  task automatic test_buf_valid();
    buf_valid = 1'b0;
    tready    = 1'b0;
    do_start();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (tvalid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bufv_wait%0d got tvalid=%b busy=%b want 0/1", c, tvalid, busy);
      end
    end
    buf_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (tvalid !== 1'b1 || tdata !== 8'h00) begin n_fail++; $display("FAIL bufv_first got tvalid=%b data=%h want 1/00", tvalid, tdata); end
    collect(0, 400);
    n_checks++; if (got_d.size() != 144 || timed_out) begin n_fail++; $display("FAIL bufv_count got %0d want 144", got_d.size()); end
  endtask

  task automatic test_reset_mid();
    int  cnt;
    bit  hit;
    cnt = 0;
    hit = 0;
    tready = 1'b1;
    do_start();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tvalid === 1'b1 && cnt == 40) begin
        tready = 1'b0;
        hit    = 1;
        break;
      end
      if (tvalid === 1'b1) cnt++;
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach got %0d beats want 40", cnt); end
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid got %b want 0", tvalid); end
    n_checks++; if (sel !== 3'd0) begin n_fail++; $display("FAIL rstmid_sel got %0d want 0", sel); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    do_start();
    collect(0, 400);
    n_checks++; if (got_d.size() != 144 || timed_out) begin n_fail++; $display("FAIL rstmid_count got %0d want 144", got_d.size()); end
    n_checks++; if (got_d.size() == 0 || got_d[0] !== 8'h00 || got_d[1] !== 8'h00 || got_d[2] !== 8'h01) begin
      n_fail++; $display("FAIL rstmid_restart got first beats wrong want 00 00 01");
    end
    n_checks++; if (sel_hist.size() == 0 || sel_hist[0] != 0) begin n_fail++; $display("FAIL rstmid_sel0 want kernel 0 first"); end
  endtask

  task automatic test_start_ignored();
    do_start();
    fork
      collect(0, 400);
      begin
        for (int p = 0; p < 20; p++) begin
          @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          repeat (5) @(negedge clk);
        end
      end
    join
    // collect() returns in the o_done cycle; a start here must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (got_d.size() != 144 || timed_out) begin n_fail++; $display("FAIL start_count got %0d want 144", got_d.size()); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL start_done got %0d want 1", done_cnt); end
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done%0d got busy=%b want 0", c, busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_depth1();
    int cnt, sel_bad, dcyc;
    cnt = 0;
    sel_bad = 0;
    dcyc = -1;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (s_sel !== 1'b0) sel_bad++;
      if (s_done === 1'b1) begin
        dcyc = c;
        break;
      end
      if (s_tvalid === 1'b1) begin
        n_checks++;
        if (s_tdata !== 8'((cnt / 3) * 16 + cnt % 3) || s_tlast !== (cnt == 8)) begin
          n_fail++;
          $display("FAIL d1_beat%0d got %h/%b want %h/%b", cnt, s_tdata, s_tlast,
                   8'((cnt / 3) * 16 + cnt % 3), (cnt == 8));
        end
        cnt++;
      end
    end
    n_checks++; if (cnt != 9) begin n_fail++; $display("FAIL d1_count got %0d want 9", cnt); end
    n_checks++; if (sel_bad != 0) begin n_fail++; $display("FAIL d1_sel got %0d nonzero cycles want 0", sel_bad); end
    n_checks++; if (dcyc != 11) begin n_fail++; $display("FAIL d1_latency got %0d want 11", dcyc); end
  endtask

  initial begin
    areset    = 1'b1;
    start     = 1'b0;
    buf_valid = 1'b1;
    tready    = 1'b1;
    s_start   = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_buf_valid();
    test_reset_mid();
    test_start_ignored();
    test_depth1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
